// File: rtl/slot_pkg.sv
// Shared types, constants and symbol arithmetic for the slot reel engine.
package slot_pkg;

   localparam int unsigned NUM_REELS = 4;
   localparam int unsigned SYM_W     = 4;
   localparam int unsigned REELS_W   = NUM_REELS * SYM_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SPIN,
      ST_STOPPING,
      ST_EVAL,
      ST_RESULT
   } reel_state_t;

   typedef enum logic [1:0] {
      WIN_NONE  = 2'd0,
      WIN_PAIR  = 2'd1,
      WIN_THREE = 2'd2,
      WIN_FOUR  = 2'd3
   } win_t;

   // Modular add by one conditional subtract; exact while sym < nsym and inc <= nsym.
   function automatic logic [SYM_W-1:0] sym_add(
      input logic [SYM_W-1:0] sym,
      input logic [SYM_W-1:0] inc,
      input logic [SYM_W:0]   nsym
   );
      logic [SYM_W:0] sum;
      sum = {1'b0, sym} + {1'b0, inc};
      if (sum >= nsym) sum = sum - nsym;
      return sum[SYM_W-1:0];
   endfunction

endpackage

// File: rtl/slot_win_eval.sv
// Scores four reel symbols by largest group of equal values.
module slot_win_eval
   import slot_pkg::*;
(
   input  logic [REELS_W-1:0] reels_i,
   output win_t               win_c_o
);

   logic [2:0] pair_cnt;

   // Equal-pair count maps uniquely: 6 four-of-a-kind, 3 three, 1 or 2 pair(s), 0 none.
   always_comb begin
      pair_cnt = '0;
      for (int unsigned a = 0; a < NUM_REELS; a++) begin
         for (int unsigned b = a + 1; b < NUM_REELS; b++) begin
            if (reels_i[a*SYM_W +: SYM_W] == reels_i[b*SYM_W +: SYM_W])
               pair_cnt = pair_cnt + 3'd1;
         end
      end
      unique case (pair_cnt)
         3'd0:    win_c_o = WIN_NONE;
         3'd3:    win_c_o = WIN_THREE;
         3'd6:    win_c_o = WIN_FOUR;
         default: win_c_o = WIN_PAIR;
      endcase
   end

endmodule

// File: rtl/slot_reel_engine.sv
// Reel-spin controller: advances four reels on step_tick, stops them in
// sequence on a button press, then scores the final combination.
module slot_reel_engine
   import slot_pkg::*;
#(
   parameter int unsigned NUM_SYMBOLS    = 10,
   parameter int unsigned MIN_SPIN_TICKS = 8,
   parameter int unsigned STOP_GAP       = 4
) (
   input  logic               mclk,
   input  logic               rst,
   input  logic               step_tick,
   input  logic               btn,
   output logic [REELS_W-1:0] reels,
   output logic               spinning,
   output logic [1:0]         win,
   output logic               done
);

   localparam int unsigned SPIN_CNT_W = $clog2(MIN_SPIN_TICKS + 1);
   localparam int unsigned GAP_W      = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;
   localparam int unsigned IDX_W      = $clog2(NUM_REELS);
   localparam logic [SYM_W:0] NSYM    = (SYM_W+1)'(NUM_SYMBOLS);

   reel_state_t              state_q;
   logic [REELS_W-1:0]       reels_q;
   logic [NUM_REELS-1:0]     stopped_q;
   logic [SPIN_CNT_W-1:0]    spin_cnt_q;
   logic [GAP_W-1:0]         gap_cnt_q;
   logic [IDX_W-1:0]         stop_idx_q;
   logic                     btn_q;
   win_t                     win_q;
   logic                     done_q;
   logic                     spinning_q;

   logic                     press_c;
   logic                     gap_last_c;
   logic                     spin_ready_c;
   logic [NUM_REELS-1:0]     freeze_c;
   logic [NUM_REELS-1:0]     stopped_d;
   logic [REELS_W-1:0]       reels_spin_d;
   logic [REELS_W-1:0]       reels_stop_d;
   win_t                     win_c;

   slot_win_eval u_win_eval (
      .reels_i (reels_q),
      .win_c_o (win_c)
   );

   // Next reel values for a tick: all reels in SPIN, only unfrozen ones in STOPPING.
   always_comb begin
      press_c      = btn & ~btn_q;
      spin_ready_c = (spin_cnt_q == SPIN_CNT_W'(MIN_SPIN_TICKS));
      gap_last_c   = (gap_cnt_q == GAP_W'(STOP_GAP - 1));
      freeze_c     = '0;
      if (gap_last_c) freeze_c[stop_idx_q] = 1'b1;
      stopped_d    = stopped_q | freeze_c;
      reels_spin_d = reels_q;
      reels_stop_d = reels_q;
      for (int unsigned i = 0; i < NUM_REELS; i++) begin
         reels_spin_d[i*SYM_W +: SYM_W] = sym_add(reels_q[i*SYM_W +: SYM_W], SYM_W'(i + 1), NSYM);
         if (!stopped_d[i])
            reels_stop_d[i*SYM_W +: SYM_W] = reels_spin_d[i*SYM_W +: SYM_W];
      end
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         reels_q    <= '0;
         stopped_q  <= '0;
         spin_cnt_q <= '0;
         gap_cnt_q  <= '0;
         stop_idx_q <= '0;
         btn_q      <= 1'b0;
         win_q      <= WIN_NONE;
         done_q     <= 1'b0;
         spinning_q <= 1'b0;
      end else begin
         btn_q  <= btn;
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_RESULT: begin
               if (press_c) begin
                  state_q    <= ST_SPIN;
                  stopped_q  <= '0;
                  spin_cnt_q <= '0;
                  win_q      <= WIN_NONE;
                  spinning_q <= 1'b1;
               end
            end
            ST_SPIN: begin
               if (step_tick) begin
                  reels_q <= reels_spin_d;
                  if (!spin_ready_c) spin_cnt_q <= spin_cnt_q + SPIN_CNT_W'(1);
               end
               // A coincident tick still lands in reels_q, so reel 0 freezes post-advance.
               if (press_c && spin_ready_c) begin
                  state_q    <= ST_STOPPING;
                  stopped_q  <= NUM_REELS'(1);
                  stop_idx_q <= IDX_W'(1);
                  gap_cnt_q  <= '0;
               end
            end
            ST_STOPPING: begin
               if (step_tick) begin
                  reels_q   <= reels_stop_d;
                  stopped_q <= stopped_d;
                  if (gap_last_c) begin
                     gap_cnt_q  <= '0;
                     stop_idx_q <= stop_idx_q + IDX_W'(1);
                     if (stop_idx_q == IDX_W'(NUM_REELS - 1)) begin
                        state_q    <= ST_EVAL;
                        spinning_q <= 1'b0;
                     end
                  end else begin
                     gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                  end
               end
            end
            ST_EVAL: begin
               win_q   <= win_c;
               done_q  <= 1'b1;
               state_q <= ST_RESULT;
            end
            default: begin
               state_q    <= ST_IDLE;
               spinning_q <= 1'b0;
            end
         endcase
      end
   end

   assign reels    = reels_q;
   assign spinning = spinning_q;
   assign win      = win_q;
   assign done     = done_q;

endmodule

// File: tb/tb_slot_reel_engine.sv
// Scoreboarded directed bench for slot_reel_engine: expected results are
// queued by the stimulus and compared by a monitor on every done pulse.
module tb_slot_reel_engine;
   import slot_pkg::*;

   logic               mclk = 1'b0;
   logic               rst = 1'b0;
   logic               step_tick = 1'b0;
   logic               btn = 1'b0;
   logic [REELS_W-1:0] reels;
   logic               spinning;
   logic [1:0]         win;
   logic               done;

   logic [REELS_W-1:0] ev_reels = '0;
   win_t               ev_win;

   typedef struct packed {
      logic [REELS_W-1:0] reels;
      logic [1:0]         win;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   done_cnt  = 0;

   slot_reel_engine #(
      .NUM_SYMBOLS    (10),
      .MIN_SPIN_TICKS (8),
      .STOP_GAP       (4)
   ) dut (
      .mclk      (mclk),
      .rst       (rst),
      .step_tick (step_tick),
      .btn       (btn),
      .reels     (reels),
      .spinning  (spinning),
      .win       (win),
      .done      (done)
   );

   slot_win_eval u_eval (
      .reels_i (ev_reels),
      .win_c_o (ev_win)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued game result.
   always @(negedge mclk) begin
      if (done === 1'b1) begin
         exp_t e;
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_done: done with reels 0x%0h win %0d, none expected", reels, win);
         end else begin
            e = exp_q.pop_front();
            chk("sb_reels", 32'(reels), 32'(e.reels));
            chk("sb_win", 32'(win), 32'(e.win));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge mclk);
   endtask

   task automatic tick();
      @(negedge mclk) step_tick = 1'b1;
      @(negedge mclk) step_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic press();
      @(negedge mclk) btn = 1'b1;
      @(negedge mclk) btn = 1'b0;
   endtask

   // Final freeze tick, then the EVAL/RESULT timing of done.
   task automatic last_tick();
      @(negedge mclk) step_tick = 1'b1;
      @(negedge mclk) step_tick = 1'b0;
      chk("spinning_falls_at_eval", 32'(spinning), 32'd0);
      chk("done_low_in_eval", 32'(done), 32'd0);
      @(negedge mclk);
      chk("done_two_cycles_after_freeze", 32'(done), 32'd1);
      @(negedge mclk);
      chk("done_single_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      #1 rst = 1'b1;
      idle(3);
      chk("reset_reels", 32'(reels), 32'd0);
      chk("reset_spinning", 32'(spinning), 32'd0);
      chk("reset_win", 32'(win), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      rst = 1'b0;
      idle(2);

      // Game 1 from reset: early press ignored, stop after 8 ticks.
      press();
      chk("g1_spinning", 32'(spinning), 32'd1);
      chk("g1_reels_start", 32'(reels), 32'd0);
      ticks(3);
      chk("g1_three_ticks", 32'(reels), 32'h2963);
      ticks(2);
      press();
      chk("g1_early_press_still_spin", 32'(spinning), 32'd1);
      tick();
      chk("g1_advance_after_early_press", 32'(reels), 32'h4826);
      ticks(2);
      chk("g1_eight_ticks", 32'(reels), 32'h2468);
      press();
      ticks(3);
      chk("g1_reel0_frozen", 32'(reels), 32'h4328);
      press();
      chk("g1_press_in_stopping_ignored", 32'(reels), 32'h4328);
      tick();
      chk("g1_reel1_freeze_tick4", 32'(reels), 32'h8628);
      ticks(4);
      chk("g1_reel2_freeze_tick8", 32'(reels), 32'h4528);
      chk("g1_spinning_in_stopping", 32'(spinning), 32'd1);
      ticks(3);
      exp_q.push_back('{reels: 16'h6528, win: 2'd0});
      last_tick();
      idle(5);
      chk("g1_done_count", 32'(done_cnt), 32'd1);

      // Game 2: button held 100 cycles in RESULT gives a single restart.
      @(negedge mclk) btn = 1'b1;
      ticks(16);
      idle(67);
      chk("g2_held_btn_still_spinning", 32'(spinning), 32'd1);
      chk("g2_held_btn_reels", 32'(reels), 32'h0344);
      chk("g2_held_btn_no_done", 32'(done_cnt), 32'd1);
      @(negedge mclk) btn = 1'b0;
      idle(2);
      press();
      ticks(11);
      exp_q.push_back('{reels: 16'h4404, win: 2'd2});
      last_tick();
      chk("g2_win_held_in_result", 32'(win), 32'd2);
      idle(3);

      // Game 3: restart clears win; stop press coincident with a tick.
      press();
      chk("g3_win_cleared", 32'(win), 32'd0);
      ticks(8);
      @(negedge mclk) begin btn = 1'b1; step_tick = 1'b1; end
      @(negedge mclk) begin btn = 1'b0; step_tick = 1'b0; end
      chk("g3_coincident_reels", 32'(reels), 32'h0183);
      ticks(3);
      chk("g3_reel0_post_advance", 32'(reels[SYM_W-1:0]), 32'd3);
      ticks(8);
      exp_q.push_back('{reels: 16'h4243, win: 2'd1});
      last_tick();
      idle(3);

      // Game 4: asynchronous reset while STOPPING.
      press();
      ticks(8);
      press();
      ticks(2);
      @(posedge mclk);
      #2 rst = 1'b1;
      #1;
      chk("g4_async_reset_reels", 32'(reels), 32'd0);
      chk("g4_async_reset_spinning", 32'(spinning), 32'd0);
      chk("g4_async_reset_done", 32'(done), 32'd0);
      idle(2);
      rst = 1'b0;
      ticks(15);
      chk("g4_tick_in_idle_no_effect", 32'(reels), 32'd0);
      chk("g4_no_done_after_reset", 32'(done_cnt), 32'd3);

      // Game 5 from reset: stop after 10 ticks.
      press();
      ticks(10);
      press();
      ticks(11);
      exp_q.push_back('{reels: 16'h4160, win: 2'd0});
      last_tick();
      idle(3);
      chk("g5_done_count", 32'(done_cnt), 32'd4);

      // Scorer on combinations the reel arithmetic cannot reach from reset.
      ev_reels = 16'h7777; #1 chk("eval_four", 32'(ev_win), 32'd3);
      ev_reels = 16'h7772; #1 chk("eval_three", 32'(ev_win), 32'd2);
      ev_reels = 16'h1155; #1 chk("eval_two_pair", 32'(ev_win), 32'd1);
      ev_reels = 16'h0123; #1 chk("eval_none", 32'(ev_win), 32'd0);
      ev_reels = 16'h9391; #1 chk("eval_one_pair", 32'(ev_win), 32'd1);

      idle(2);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
